spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter_pkg.sv | 18 +
 rtl/spi_flash_rr_arb.sv | 40 ++++
 rtl/spi_flash_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared definitions for the SPI flash read arbiter.
//   state_e   : arbiter FSM states
//   LEN_W_DEF : default width of the requester byte-length fields
//   MLEN_W    : width of the master bit-count field (m_words_to_read)
package spi_flash_arbiter_pkg;

    localparam int LEN_W_DEF = 15;
    localparam int MLEN_W    = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STREAM,
        ST_ACK,
        ST_SETTLE
    } state_e;

endpackage

// File: rtl/spi_flash_rr_arb.sv
// Two-way request arbiter with a last-served flag.
//   clk, reset  : clock, synchronous active-high reset
//   req_i[1:0]  : request vector {r1, r0}
//   upd_i       : pulse, record upd_idx_i as the last-served requester
//   upd_idx_i   : index of the requester just served
//   win_o       : index of the winning requester (valid when any req_i set)
module spi_flash_rr_arb
    import spi_flash_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic       win_o
);

    // Resets to 1 so that requester 0 wins the first contended round.
    logic last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= upd_idx_i;
        end
    end

    always_comb begin
        win_o = 1'b0;
        if (req_i == 2'b11) begin
            win_o = RR_EN ? ~last_q : 1'b0;
        end else begin
            win_o = req_i[1] & ~req_i[0];
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates two byte-read requesters onto one SPI flash master.
//   clk, reset                 : clock, synchronous active-high reset
//   rN_req/rN_addr/rN_len      : requester read command (N=0,1)
//   rN_gnt/valid/data/done/err : requester grant, byte stream, completion
//   m_en/m_read_req/m_addr/
//   m_words_to_read/m_wr_data  : command to the SPI master
//   m_valid/m_rd_data/
//   m_end_transaction          : read stream and completion from the master
//   m_rd_ack                   : completion acknowledge to the master
module spi_flash_arbiter
    import spi_flash_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [23:0]       r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    output logic              r0_gnt,
    output logic              r0_valid,
    output logic [7:0]        r0_data,
    output logic              r0_done,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic [23:0]       r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    output logic              r1_gnt,
    output logic              r1_valid,
    output logic [7:0]        r1_data,
    output logic              r1_done,
    output logic              r1_err,
    output logic              m_en,
    output logic              m_read_req,
    output logic [23:0]       m_addr,
    output logic [MLEN_W-1:0] m_words_to_read,
    output logic [7:0]        m_wr_data,
    input  logic              m_valid,
    input  logic [7:0]        m_rd_data,
    input  logic              m_end_transaction,
    output logic              m_rd_ack
);

    state_e             state_q;
    logic               idx_q;
    logic [1:0]         gnt_q;
    logic               done_q, err_q, m_en_q, ack_q;
    logic [23:0]        addr_q;
    logic [MLEN_W-1:0]  words_q;
    logic [LEN_W-1:0]   byte_cnt_q;  // observability only, no control effect

    logic               win;
    logic [23:0]        sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               stream_v;

    spi_flash_rr_arb #(.RR_EN(RR_EN)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({r1_req, r0_req}),
        .upd_i     (state_q == ST_ACK),
        .upd_idx_i (idx_q),
        .win_o     (win)
    );

    always_comb begin
        sel_addr = win ? r1_addr : r0_addr;
        sel_len  = win ? r1_len  : r0_len;
    end

    assign stream_v = (state_q == ST_STREAM) && m_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            m_en_q     <= 1'b0;
            ack_q      <= 1'b0;
            addr_q     <= '0;
            words_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            // Strobe outputs are single-cycle unless re-asserted below.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            m_en_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Never start while the master is still ending a transfer.
                    if ((r0_req || r1_req) && !m_end_transaction) begin
                        idx_q      <= win;
                        gnt_q      <= win ? 2'b10 : 2'b01;
                        addr_q     <= sel_addr;
                        words_q    <= MLEN_W'({sel_len, 3'b000});
                        byte_cnt_q <= '0;
                        state_q    <= ST_ISSUE;
                        // Zero length is rejected in the ISSUE cycle, no master start.
                        if (sel_len == '0) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            m_en_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (err_q) begin
                        gnt_q   <= 2'b00;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (m_valid) byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                    if (m_end_transaction) begin
                        ack_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: state_q <= ST_SETTLE;
                ST_SETTLE: begin
                    if (!m_end_transaction) begin
                        gnt_q   <= 2'b00;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r0_gnt   = gnt_q[0];
    assign r1_gnt   = gnt_q[1];
    assign r0_valid = stream_v & ~idx_q;
    assign r1_valid = stream_v &  idx_q;
    assign r0_data  = r0_valid ? m_rd_data : 8'h00;
    assign r1_data  = r1_valid ? m_rd_data : 8'h00;
    assign r0_done  = done_q & ~idx_q;
    assign r1_done  = done_q &  idx_q;
    assign r0_err   = err_q  & ~idx_q;
    assign r1_err   = err_q  &  idx_q;

    assign m_en            = m_en_q;
    assign m_read_req      = 1'b1;
    assign m_addr          = addr_q;
    assign m_words_to_read = words_q;
    assign m_wr_data       = 8'h00;
    assign m_rd_ack        = ack_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [23:0] r0_addr = '0, r1_addr = '0;
    logic [14:0] r0_len = '0, r1_len = '0;
    logic        m_valid = 1'b0, m_end_transaction = 1'b0;
    logic [7:0]  m_rd_data = '0;

    logic        r0_gnt, r0_valid, r0_done, r0_err, r1_gnt, r1_valid, r1_done, r1_err;
    logic [7:0]  r0_data, r1_data, m_wr_data;
    logic        m_en, m_read_req, m_rd_ack;
    logic [23:0] m_addr;
    logic [17:0] m_words_to_read;

    logic        f_r0_gnt, f_r0_valid, f_r0_done, f_r0_err, f_r1_gnt, f_r1_valid, f_r1_done, f_r1_err;
    logic [7:0]  f_r0_data, f_r1_data, f_m_wr_data;
    logic        f_m_en, f_m_read_req, f_m_rd_ack;
    logic [23:0] f_m_addr;
    logic [17:0] f_m_words_to_read;

    int checks = 0, errors = 0;
    int en_cnt = 0, ack_cnt = 0, v0_cnt = 0, v1_cnt = 0, d0_cnt = 0, d1_cnt = 0, g1_cnt = 0;

    always #5 clk = ~clk;

    spi_flash_arbiter #(.RR_EN(1'b1), .LEN_W(15)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_len(r0_len), .r0_gnt(r0_gnt),
        .r0_valid(r0_valid), .r0_data(r0_data), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_len(r1_len), .r1_gnt(r1_gnt),
        .r1_valid(r1_valid), .r1_data(r1_data), .r1_done(r1_done), .r1_err(r1_err),
        .m_en(m_en), .m_read_req(m_read_req), .m_addr(m_addr),
        .m_words_to_read(m_words_to_read), .m_wr_data(m_wr_data),
        .m_valid(m_valid), .m_rd_data(m_rd_data),
        .m_end_transaction(m_end_transaction), .m_rd_ack(m_rd_ack)
    );

    spi_flash_arbiter #(.RR_EN(1'b0), .LEN_W(15)) dut_fp (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_len(r0_len), .r0_gnt(f_r0_gnt),
        .r0_valid(f_r0_valid), .r0_data(f_r0_data), .r0_done(f_r0_done), .r0_err(f_r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_len(r1_len), .r1_gnt(f_r1_gnt),
        .r1_valid(f_r1_valid), .r1_data(f_r1_data), .r1_done(f_r1_done), .r1_err(f_r1_err),
        .m_en(f_m_en), .m_read_req(f_m_read_req), .m_addr(f_m_addr),
        .m_words_to_read(f_m_words_to_read), .m_wr_data(f_m_wr_data),
        .m_valid(m_valid), .m_rd_data(m_rd_data),
        .m_end_transaction(m_end_transaction), .m_rd_ack(f_m_rd_ack)
    );

    // Pulse counters for the RR instance; tests compare deltas.
    always @(posedge clk) begin
        if (m_en)     en_cnt++;
        if (m_rd_ack) ack_cnt++;
        if (r0_valid) v0_cnt++;
        if (r1_valid) v1_cnt++;
        if (r0_done)  d0_cnt++;
        if (r1_done)  d1_cnt++;
        if (r1_gnt)   g1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int w);
        return (w != 0) ? r1_gnt : r0_gnt;
    endfunction
    function automatic logic valid_of(input int w);
        return (w != 0) ? r1_valid : r0_valid;
    endfunction
    function automatic logic [7:0] data_of(input int w);
        return (w != 0) ? r1_data : r0_data;
    endfunction
    function automatic logic done_of(input int w);
        return (w != 0) ? r1_done : r0_done;
    endfunction
    function automatic logic err_of(input int w);
        return (w != 0) ? r1_err : r0_err;
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt"},   {r0_gnt, r1_gnt}, 0);
        chk({tag, "_valid"}, {r0_valid, r1_valid}, 0);
        chk({tag, "_done"},  {r0_done, r1_done, r0_err, r1_err}, 0);
        chk({tag, "_data"},  {r0_data, r1_data, m_wr_data}, 0);
        chk({tag, "_m_en"},  {m_en, m_rd_ack}, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_words"}, m_words_to_read, 0);
        chk({tag, "_m_read_req"}, m_read_req, 1);
    endtask

    // Grant cycle after the IDLE latch, then the one-cycle m_en check.
    task automatic start(input int who, input logic [23:0] addr, input int len);
        tick();
        chk("gnt", gnt_of(who), 1);
        chk("gnt_other", gnt_of(1 - who), 0);
        chk("m_en", m_en, 1);
        chk("m_addr", m_addr, addr);
        chk("m_words", m_words_to_read, len * 8);
        tick();
        chk("m_en_one_cycle", m_en, 0);
    endtask

    task automatic stream(input int who, input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            m_valid   = 1'b1;
            m_rd_data = seed + 8'(i * 17);
            #1;
            chk("valid", valid_of(who), 1);
            chk("data", data_of(who), seed + 8'(i * 17));
            chk("valid_other", valid_of(1 - who), 0);
            tick();
        end
        m_valid   = 1'b0;
        m_rd_data = 8'h00;
    endtask

    task automatic end_xfer(input int who, input int hold, input bit drop);
        int n;
        m_end_transaction = 1'b1;
        tick();
        chk("ack", m_rd_ack, 1);
        chk("done", done_of(who), 1);
        chk("err", err_of(who), 0);
        chk("done_other", done_of(1 - who), 0);
        if (drop) begin
            if (who != 0) r1_req = 1'b0; else r0_req = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_ack", m_rd_ack, 0);
            chk("hold_m_en", m_en, 0);
            chk("hold_gnt", gnt_of(who), 1);
        end
        m_end_transaction = 1'b0;
        n = 0;
        while ((r0_gnt || r1_gnt) && n < 8) begin
            tick();
            n++;
        end
        chk("settle_release", {r0_gnt, r1_gnt}, 0);
    endtask

    initial begin
        int b0, b1, b2, b3;

        // Reset state
        tick();
        tick();
        chk_idle_outs("reset");
        reset = 1'b0;

        // Single read, len 4
        b0 = v0_cnt; b1 = d0_cnt; b2 = v1_cnt + d1_cnt + g1_cnt;
        r0_addr = 24'h001000; r0_len = 15'd4; r0_req = 1'b1;
        start(0, 24'h001000, 4);
        stream(0, 4, 8'hA1);
        end_xfer(0, 0, 1'b1);
        chk("t1_valid_count", v0_cnt - b0, 4);
        chk("t1_done_count", d0_cnt - b1, 1);
        chk("t1_r1_quiet", v1_cnt + d1_cnt + g1_cnt - b2, 0);

        // Simultaneous requests from reset: RR vs fixed priority
        reset = 1'b1; tick(); reset = 1'b0;
        r0_addr = 24'h002000; r0_len = 15'd2;
        r1_addr = 24'h003000; r1_len = 15'd2;
        r0_req = 1'b1; r1_req = 1'b1;
        start(0, 24'h002000, 2);
        chk("fp_first_r0", {f_r1_gnt, f_r0_gnt}, 2'b01);
        stream(0, 2, 8'h10);
        end_xfer(0, 0, 1'b0);
        start(1, 24'h003000, 2);
        chk("fp_second_r0", {f_r1_gnt, f_r0_gnt}, 2'b01);
        stream(1, 2, 8'h20);
        end_xfer(1, 0, 1'b0);
        r0_req = 1'b0;
        start(1, 24'h003000, 2);
        chk("fp_third_r1", {f_r1_gnt, f_r0_gnt}, 2'b10);
        stream(1, 2, 8'h30);
        end_xfer(1, 0, 1'b1);

        // Zero-length request on r1
        b0 = en_cnt;
        r1_addr = 24'h004000; r1_len = 15'd0; r1_req = 1'b1;
        tick();
        chk("zl_gnt", r1_gnt, 1);
        chk("zl_done_err", {r1_done, r1_err}, 2'b11);
        chk("zl_r0_quiet", {r0_done, r0_err}, 0);
        chk("zl_m_en", m_en, 0);
        r1_req = 1'b0;
        tick();
        chk("zl_pulse_end", {r1_done, r1_err, r1_gnt}, 0);
        tick();
        chk("zl_no_m_en", en_cnt - b0, 0);

        // m_end_transaction held after ack with r0 pending
        b0 = ack_cnt;
        r0_addr = 24'h005000; r0_len = 15'd1; r0_req = 1'b1;
        start(0, 24'h005000, 1);
        stream(0, 1, 8'h55);
        end_xfer(0, 3, 1'b0);
        chk("hold_no_early_m_en", m_en, 0);
        start(0, 24'h005000, 1);
        chk("hold_one_ack", ack_cnt - b0, 1);
        stream(0, 1, 8'h66);
        end_xfer(0, 0, 1'b1);
        chk("hold_two_acks", ack_cnt - b0, 2);

        // Reset during STREAM of a len 16 read
        r0_addr = 24'h006000; r0_len = 15'd16; r0_req = 1'b1;
        start(0, 24'h006000, 16);
        stream(0, 3, 8'h01);
        b0 = ack_cnt;
        m_valid = 1'b1; m_rd_data = 8'hEE;
        reset = 1'b1; r0_req = 1'b0;
        tick();
        chk_idle_outs("midrst");
        reset = 1'b0; m_valid = 1'b0; m_rd_data = 8'h00;
        chk("midrst_no_ack", ack_cnt - b0, 0);
        r0_addr = 24'h007000; r0_len = 15'd2; r0_req = 1'b1;
        start(0, 24'h007000, 2);
        stream(0, 2, 8'h70);
        end_xfer(0, 0, 1'b1);
        chk("midrst_recover_ack", ack_cnt - b0, 1);

        // Requester drops req after first byte; addr/len changes ignored
        b0 = v0_cnt; b1 = d0_cnt;
        r0_addr = 24'h008000; r0_len = 15'd8; r0_req = 1'b1;
        start(0, 24'h008000, 8);
        stream(0, 1, 8'h80);
        r0_req = 1'b0; r0_addr = 24'h009999; r0_len = 15'd3;
        stream(0, 7, 8'h91);
        chk("drop_addr_stable", m_addr, 24'h008000);
        chk("drop_words_stable", m_words_to_read, 64);
        end_xfer(0, 0, 1'b0);
        chk("drop_valid_count", v0_cnt - b0, 8);
        chk("drop_done_count", d0_cnt - b1, 1);
        tick();
        chk("drop_no_regrant", r0_gnt, 0);

        b3 = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors + b3);
        $finish;
    end

endmodule
